// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the instruction fetch controller and its skid entry.
// No logic; widths, state encoding, reset PC default and enable levels only.
package fetch_ctrl_pkg;

    localparam int unsigned INST_ADDR_W = 32;
    localparam int unsigned INST_W      = 32;

    typedef logic [INST_ADDR_W-1:0] inst_addr_t;
    typedef logic [INST_W-1:0]      inst_t;

    localparam inst_addr_t RESET_PC_DEF = 32'h0000_0000;
    localparam inst_addr_t PC_STEP      = 32'd4;
    localparam inst_addr_t ALIGN_MASK   = 32'hFFFF_FFFC;

    localparam logic EN  = 1'b1;
    localparam logic DIS = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DROP = 2'd2,
        ST_HOLD = 2'd3
    } fetch_state_e;

    function automatic inst_addr_t align_pc(input inst_addr_t a);
        return a & ALIGN_MASK;
    endfunction

endpackage

// File: rtl/fetch_skid.sv
// One-entry holding slot for an instruction that returned while the decode stage was stalled.
// Load/unload/clear take effect on the next edge; clear and unload win over load.
module fetch_skid
    import fetch_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load_i,
    input  logic       unload_i,
    input  logic       clear_i,
    input  inst_addr_t pc_i,
    input  inst_t      inst_i,
    output logic       vld_o,
    output inst_addr_t pc_o,
    output inst_t      inst_o
);

    logic       vld_q,  vld_d;
    inst_addr_t pc_q,   pc_d;
    inst_t      inst_q, inst_d;

    always_comb begin
        vld_d  = vld_q;
        pc_d   = pc_q;
        inst_d = inst_q;
        if (clear_i || unload_i) begin
            vld_d = DIS;
        end else if (load_i) begin
            vld_d  = EN;
            pc_d   = pc_i;
            inst_d = inst_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_q  <= DIS;
            pc_q   <= '0;
            inst_q <= '0;
        end else begin
            vld_q  <= vld_d;
            pc_q   <= pc_d;
            inst_q <= inst_d;
        end
    end

    assign vld_o  = vld_q;
    assign pc_o   = pc_q;
    assign inst_o = inst_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: one outstanding memory request, redirect handling, skid on stall.
// Delivery registered one edge after ack; stall holds outputs, a returning fetch parks in the skid.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter inst_addr_t RESET_PC = RESET_PC_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       stall_i,
    input  logic       branch_i,
    input  inst_addr_t branch_target_i,
    input  logic       flush_i,
    input  inst_addr_t flush_pc_i,
    output logic       inst_req_o,
    output inst_addr_t inst_addr_o,
    input  logic       inst_ack_i,
    input  inst_t      inst_rdata_i,
    output logic       if_valid_o,
    output inst_addr_t if_pc_o,
    output inst_t      if_inst_o
);

    fetch_state_e st_q,      st_d;
    logic         req_q,     req_d;
    inst_addr_t   addr_q,    addr_d;
    inst_addr_t   tgt_q,     tgt_d;
    logic         vld_q,     vld_d;
    inst_addr_t   if_pc_q,   if_pc_d;
    inst_t        if_inst_q, if_inst_d;

    logic         redirect;
    inst_addr_t   redir_tgt;
    logic         skid_load, skid_unload, skid_clear;
    logic         skid_vld;
    inst_addr_t   skid_pc;
    inst_t        skid_inst;

    assign redirect  = flush_i | branch_i;
    assign redir_tgt = align_pc(flush_i ? flush_pc_i : branch_target_i);

    always_comb begin
        st_d        = st_q;
        req_d       = req_q;
        addr_d      = addr_q;
        tgt_d       = tgt_q;
        vld_d       = vld_q;
        if_pc_d     = if_pc_q;
        if_inst_d   = if_inst_q;
        skid_load   = DIS;
        skid_unload = DIS;
        skid_clear  = DIS;

        if (redirect) begin
            vld_d      = DIS;
            skid_clear = EN;
            // A request still in flight must finish before the target can be fetched.
            if (req_q && !inst_ack_i) begin
                st_d  = ST_DROP;
                tgt_d = redir_tgt;
            end else begin
                st_d   = ST_REQ;
                req_d  = EN;
                addr_d = redir_tgt;
            end
        end else begin
            case (st_q)
                ST_IDLE: begin
                    st_d  = ST_REQ;
                    req_d = EN;
                end
                ST_REQ: begin
                    if (inst_ack_i) begin
                        addr_d = addr_q + PC_STEP;
                        if (stall_i) begin
                            skid_load = EN;
                            req_d     = DIS;
                            st_d      = ST_HOLD;
                        end else begin
                            vld_d     = EN;
                            if_pc_d   = addr_q;
                            if_inst_d = inst_rdata_i;
                        end
                    end else if (!stall_i) begin
                        vld_d = DIS;
                    end
                end
                ST_DROP: begin
                    if (inst_ack_i) begin
                        st_d   = ST_REQ;
                        addr_d = tgt_q;
                    end
                end
                ST_HOLD: begin
                    if (!stall_i) begin
                        vld_d       = skid_vld;
                        if_pc_d     = skid_pc;
                        if_inst_d   = skid_inst;
                        skid_unload = EN;
                        req_d       = EN;
                        st_d        = ST_REQ;
                    end
                end
                default: st_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st_q      <= ST_IDLE;
            req_q     <= DIS;
            addr_q    <= RESET_PC;
            tgt_q     <= RESET_PC;
            vld_q     <= DIS;
            if_pc_q   <= '0;
            if_inst_q <= '0;
        end else begin
            st_q      <= st_d;
            req_q     <= req_d;
            addr_q    <= addr_d;
            tgt_q     <= tgt_d;
            vld_q     <= vld_d;
            if_pc_q   <= if_pc_d;
            if_inst_q <= if_inst_d;
        end
    end

    fetch_skid u_skid (
        .clk      (clk),
        .rst      (rst),
        .load_i   (skid_load),
        .unload_i (skid_unload),
        .clear_i  (skid_clear),
        .pc_i     (addr_q),
        .inst_i   (inst_rdata_i),
        .vld_o    (skid_vld),
        .pc_o     (skid_pc),
        .inst_o   (skid_inst)
    );

    assign inst_req_o  = req_q;
    assign inst_addr_o = addr_q;
    assign if_valid_o  = vld_q;
    assign if_pc_o     = if_pc_q;
    assign if_inst_o   = if_inst_q;

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h00000000, first fetch address after reset.
REQ-002 clk  in  1  sole clock; all state changes on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-low.
REQ-004 stall_i  in  1  downstream (IF/ID) cannot accept; hold fetch output.
REQ-005 branch_i  in  1  branch redirect request, single-cycle pulse.
REQ-006 branch_target_i  in  32  branch target address.
REQ-007 flush_i  in  1  exception flush request, single-cycle pulse.
REQ-008 flush_pc_i  in  32  exception handler address.
REQ-009 inst_req_o  out  1  instruction-memory request valid (chip enable).
REQ-010 inst_addr_o  out  32  request address.
REQ-011 inst_ack_i  in  1  one-cycle memory response strobe, latency >=1 cycle after accepted request.
REQ-012 inst_rdata_i  in  32  instruction data, valid with inst_ack_i.
REQ-013 if_valid_o  out  1  if_inst_o/if_pc_o hold a valid fetched instruction.
REQ-014 if_pc_o  out  32  address of delivered instruction.
REQ-015 if_inst_o  out  32  delivered instruction.

Function
REQ-016 States: IDLE (no request), REQ (one request outstanding), DROP (outstanding request to be discarded), HOLD (stalled, skid full, no request).
REQ-017 At most one request outstanding; inst_req_o is held high with stable inst_addr_o from issue until the ack cycle inclusive.
REQ-018 First rising edge after reset release: IDLE->REQ, inst_req_o=1, inst_addr_o=RESET_PC.
REQ-019 Ack in REQ with stall_i=0 and skid empty: next cycle if_valid_o=1, if_pc_o=request address, if_inst_o=inst_rdata_i; pc advances by 4; new request to pc+4 issued in the same cycle as delivery (back-to-back, one instruction per ack).
REQ-020 stall_i=1: if_valid_o/if_pc_o/if_inst_o held unchanged; outstanding request may complete into a one-entry skid buffer; no new request issued while stall_i=1 and skid full (state HOLD).
REQ-021 stall_i falling: skid content moves to outputs next cycle, skid empties, next request issued that cycle.
REQ-022 Redirect priority: flush_i > branch_i > stall_i > sequential; redirect target bits [1:0] forced to 2'b00.
REQ-023 Redirect with no request outstanding: skid and if_valid_o cleared next cycle; request to target issued next cycle.
REQ-024 Redirect with request outstanding: enter DROP, clear skid and if_valid_o next cycle, latch target; ack received in DROP is discarded; request to latched target issued the cycle after that ack.
REQ-025 Redirect arriving in the same cycle as an ack: that ack's data is discarded; request to target issued next cycle.
REQ-026 Second redirect while in DROP: latched target overwritten by the higher-priority/later one; remain in DROP.
REQ-027 Redirect overrides stall: outputs cleared even while stall_i=1; refetch request issued regardless of stall_i.
REQ-028 Sequential increment wraps modulo 2^32: 32'hFFFFFFFC -> 32'h00000000.

Reset
REQ-029 rst low asynchronously forces: state IDLE, inst_req_o=0, inst_addr_o=RESET_PC, pc=RESET_PC, if_valid_o=0, if_pc_o=0, if_inst_o=0, skid empty, drop flag clear.
REQ-030 Reset asserted mid-request abandons it; any ack arriving during or in the first cycle after reset is ignored.

Structure
REQ-031 Shared defines hold state encoding, RESET_PC default, InstAddrBus/InstBus widths and enable/disable constants.
REQ-032 Skid buffer is a separate sub-module fetch_skid (one entry: valid, pc, inst; load, unload, clear).

Verification
REQ-033 Reset release, ack latency 1 -> requests 0x0,0x4,0x8 back-to-back; if_pc_o 0x0,0x4,0x8 on consecutive cycles.
REQ-034 stall_i high 3 cycles while request to 0x8 outstanding -> outputs hold 0x4; 0x8 in skid; no request issued; release -> if_pc_o=0x8 next cycle, request 0xC issued.
REQ-035 branch_i to 0x103 while request 0x10 outstanding -> 0x10 data never delivered; next request address 0x100; if_valid_o low until its ack.
REQ-036 flush_i to 0x180 and branch_i to 0x200 same cycle, with stall_i=1 -> if_valid_o cleared, next request 0x180.
REQ-037 pc=0xFFFFFFFC ack -> next request 0x00000000; rst low mid-request, ack during reset -> no delivery, restart at RESET_PC.
